// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity encodings and receiver FSM state type
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - circular receive FIFO; a push into a full FIFO is accepted only alongside a pop
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign valid   = (count != '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop && valid;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = valid ? mem[rd_ptr] : '0;

    // DEPTH is a power of two, so the pointers wrap by natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver; define UART_RX_FIFO_EN for a FIFO instead of one holding register
module uart_rx_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    import uart_pkg::*;

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID_CNT   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_CNT   = CW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY_MODE == PAR_ODD);

    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) ||
        OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 ||
        FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_rx_cfg: illegal parameter set");
    end

    rx_state_t     state, state_nxt;
    logic          rx_meta, rx_sync;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic          stop_idx, stop_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          perr_acc, perr_nxt;
    logic          ferr_acc, ferr_nxt;
    logic          frame_end;
    logic          pop, full, drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            perr_acc   <= 1'b0;
            ferr_acc   <= 1'b0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_nxt;
            stop_idx   <= stop_nxt;
            shreg      <= shreg_nxt;
            perr_acc   <= perr_nxt;
            ferr_acc   <= ferr_nxt;
            rx_done    <= frame_end;
            parity_err <= frame_end && perr_nxt;
            frame_err  <= frame_end && ferr_nxt;
        end
    end

    // After the start midpoint every sample lands a full bit period later
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        stop_nxt  = stop_idx;
        shreg_nxt = shreg;
        perr_nxt  = perr_acc;
        ferr_nxt  = ferr_acc;
        frame_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    stop_nxt  = 1'b0;
                    shreg_nxt = '0;
                    perr_nxt  = 1'b0;
                    ferr_nxt  = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (cnt == MID_CNT) begin
                        cnt_nxt   = '0;
                        state_nxt = rx_sync ? IDLE : DATA;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (cnt == BIT_CNT) begin
                        cnt_nxt            = '0;
                        shreg_nxt[bit_idx] = rx_sync;
                        bit_nxt            = bit_idx + 3'd1;
                        if (bit_idx == LAST_DATA)
                            state_nxt = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (cnt == BIT_CNT) begin
                        cnt_nxt   = '0;
                        perr_nxt  = rx_sync ^ (^shreg) ^ ODD_PAR;
                        state_nxt = STOP;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (cnt == BIT_CNT) begin
                        cnt_nxt = '0;
                        if (!rx_sync) ferr_nxt = 1'b1;
                        if (stop_idx == LAST_STOP) begin
                            frame_end = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            stop_nxt = stop_idx + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx_busy = (state != IDLE);
    assign pop     = rd_en && rx_valid;
    assign drop    = rx_done && full && !pop;

    // shreg is still intact in the rx_done cycle; it is only cleared on the next START entry
`ifdef UART_RX_FIFO_EN
    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_done),
        .push_data (shreg),
        .pop       (pop),
        .rd_data   (rx_data),
        .valid     (rx_valid),
        .full      (full)
    );
`else
    logic [7:0] hold_data;
    logic       hold_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (rx_done && (!hold_valid || pop)) begin
            hold_data  <= shreg;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign full     = hold_valid;
    assign rx_valid = hold_valid;
    assign rx_data  = hold_valid ? hold_data : '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          overrun <= 1'b0;
        else if (drop)    overrun <= 1'b1;
        else if (clr_err) overrun <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed vector bench for uart_rx_cfg (8N1, 7E1 and 8N2 instances)
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       clr_err;
    logic       rx_line    [3];
    logic       rd_en_w    [3];
    logic       rx_valid_w [3];
    logic [7:0] rx_data_w  [3];
    logic       rx_done_w  [3];
    logic       perr_w     [3];
    logic       ferr_w     [3];
    logic       overrun_w  [3];
    logic       busy_w     [3];

    int checks = 0;
    int errors = 0;
    int done_cnt [3];
    int perr_cnt [3];
    int ferr_cnt [3];
    int tdiv = 0;

    typedef struct {
        int         unit;
        logic [7:0] data;
        logic       pbit;
        logic       stop1;
        logic       stop2;
        logic [7:0] exp_data;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    uart_rx_cfg u_dut0 (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx_line[0]), .rd_en(rd_en_w[0]), .clr_err(clr_err),
        .rx_valid(rx_valid_w[0]), .rx_data(rx_data_w[0]), .rx_done(rx_done_w[0]),
        .parity_err(perr_w[0]), .frame_err(ferr_w[0]), .overrun(overrun_w[0]), .rx_busy(busy_w[0])
    );

    uart_rx_cfg #(.DATA_BITS(7), .PARITY_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx_line[1]), .rd_en(rd_en_w[1]), .clr_err(clr_err),
        .rx_valid(rx_valid_w[1]), .rx_data(rx_data_w[1]), .rx_done(rx_done_w[1]),
        .parity_err(perr_w[1]), .frame_err(ferr_w[1]), .overrun(overrun_w[1]), .rx_busy(busy_w[1])
    );

    uart_rx_cfg #(.STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx_line[2]), .rd_en(rd_en_w[2]), .clr_err(clr_err),
        .rx_valid(rx_valid_w[2]), .rx_data(rx_data_w[2]), .rx_done(rx_done_w[2]),
        .parity_err(perr_w[2]), .frame_err(ferr_w[2]), .overrun(overrun_w[2]), .rx_busy(busy_w[2])
    );

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tdiv = (tdiv + 1) % 4;
            tick = (tdiv == 0);
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (rx_done_w[u]) done_cnt[u]++;
            if (perr_w[u])    perr_cnt[u]++;
            if (ferr_w[u])    ferr_cnt[u]++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input int u, input logic v, input int n);
        rx_line[u] = v;
        repeat (n) @(negedge clk);
    endtask

    // Final stop bit is cut short past its midpoint so a low stop cannot look like a real start bit
    task automatic send_frame(input int u, input logic [7:0] d, input logic pbit,
                              input logic s1, input logic s2);
        int nb;
        nb = (u == 1) ? 7 : 8;
        drive_bit(u, 1'b0, 64);
        for (int i = 0; i < nb; i++) drive_bit(u, d[i], 64);
        if (u == 1) drive_bit(u, pbit, 64);
        if (u == 2) begin
            drive_bit(u, s1, 64);
            drive_bit(u, s2, 44);
        end else begin
            drive_bit(u, s1, 44);
        end
        drive_bit(u, 1'b1, 84);
    endtask

    task automatic pop_word(input int u);
        rd_en_w[u] = 1'b1;
        @(negedge clk);
        rd_en_w[u] = 1'b0;
    endtask

    initial begin
        int d0, p0, f0, n_send, n_keep;
        bit got;

        vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 0, 0};
        vecs[1] = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 0, 0};
        vecs[2] = '{0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 0, 1};
        vecs[3] = '{1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1, 0};
        vecs[4] = '{1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h03, 0, 0};
        vecs[5] = '{1, 8'h7F, 1'b1, 1'b1, 1'b1, 8'h7F, 0, 0};
        vecs[6] = '{2, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 0, 1};
        vecs[7] = '{2, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 0, 0};

        rst = 1'b1;
        clr_err = 1'b0;
        for (int u = 0; u < 3; u++) begin
            rx_line[u] = 1'b1;
            rd_en_w[u] = 1'b0;
        end
        repeat (4) @(negedge clk);
        check("reset_rx_valid", rx_valid_w[0], 0);
        check("reset_rx_data", rx_data_w[0], 0);
        check("reset_rx_done", rx_done_w[0], 0);
        check("reset_overrun", overrun_w[0], 0);
        check("reset_rx_busy", busy_w[0], 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            int u;
            u  = vecs[v].unit;
            d0 = done_cnt[u];
            p0 = perr_cnt[u];
            f0 = ferr_cnt[u];
            send_frame(u, vecs[v].data, vecs[v].pbit, vecs[v].stop1, vecs[v].stop2);
            check($sformatf("vec%0d_done", v), done_cnt[u] - d0, 1);
            check($sformatf("vec%0d_parity_err", v), perr_cnt[u] - p0, vecs[v].exp_perr);
            check($sformatf("vec%0d_frame_err", v), ferr_cnt[u] - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_rx_valid", v), rx_valid_w[u], 1);
            check($sformatf("vec%0d_rx_data", v), rx_data_w[u], vecs[v].exp_data);
            pop_word(u);
            check($sformatf("vec%0d_drained", v), rx_valid_w[u], 0);
        end

        d0 = done_cnt[0];
        rx_line[0] = 1'b0;
        repeat (16) @(negedge clk);
        check("false_start_busy", busy_w[0], 1);
        rx_line[0] = 1'b1;
        repeat (80) @(negedge clk);
        check("false_start_idle", busy_w[0], 0);
        check("false_start_no_done", done_cnt[0] - d0, 0);
        check("false_start_no_data", rx_valid_w[0], 0);

        pop_word(0);
        check("pop_empty_ignored", rx_valid_w[0], 0);

`ifdef UART_RX_FIFO_EN
        n_send = 9;
        n_keep = 8;
`else
        n_send = 2;
        n_keep = 1;
`endif
        for (int i = 0; i < n_send; i++) send_frame(0, 8'(i), 1'b0, 1'b1, 1'b1);
        check("overrun_set", overrun_w[0], 1);
        for (int i = 0; i < n_keep; i++) begin
            check($sformatf("ovr_read%0d_valid", i), rx_valid_w[0], 1);
            check($sformatf("ovr_read%0d_data", i), rx_data_w[0], 8'(i));
            pop_word(0);
        end
        check("ovr_drained", rx_valid_w[0], 0);
        check("overrun_sticky", overrun_w[0], 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("overrun_cleared", overrun_w[0], 0);

        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
        got = 1'b0;
        fork
            send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
            begin
                for (int i = 0; i < 2000 && !got; i++) begin
                    @(negedge clk);
                    if (rx_done_w[0]) begin
                        rd_en_w[0] = 1'b1;
                        @(negedge clk);
                        rd_en_w[0] = 1'b0;
                        got = 1'b1;
                    end
                end
            end
        join
        check("pushpop_done_seen", got, 1);
        check("pushpop_no_overrun", overrun_w[0], 0);
        check("pushpop_valid", rx_valid_w[0], 1);
        check("pushpop_data", rx_data_w[0], 8'h22);
        pop_word(0);
        check("pushpop_drained", rx_valid_w[0], 0);

        d0 = done_cnt[0];
        drive_bit(0, 1'b0, 64);
        drive_bit(0, 1'b0, 64);
        drive_bit(0, 1'b0, 64);
        drive_bit(0, 1'b1, 64);
        drive_bit(0, 1'b1, 30);
        check("midframe_busy", busy_w[0], 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midframe_rst_busy", busy_w[0], 0);
        rst = 1'b0;
        rx_line[0] = 1'b1;
        repeat (300) @(negedge clk);
        check("midframe_no_done", done_cnt[0] - d0, 0);
        check("midframe_no_data", rx_valid_w[0], 0);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
        check("after_rst_done", done_cnt[0] - d0, 1);
        check("after_rst_valid", rx_valid_w[0], 1);
        check("after_rst_data", rx_data_w[0], 8'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning frame data width; legal values 5..8.
REQ-002 SHALL have parameter PARITY_MODE, default 0, meaning parity type: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked; legal values 1 or 2.
REQ-004 SHALL have parameter OVERSAMPLE, default 16, meaning ticks per bit; even, 8..32.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries; power of 2, 2..64.
REQ-006 clk  input  1  system clock; all state on posedge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 tick  input  1  one-clk oversample strobe at OVERSAMPLE x baud.
REQ-009 rx  input  1  serial line, idle high, asynchronous.
REQ-010 rd_en  input  1  pop request for rx_data.
REQ-011 clr_err  input  1  clears sticky overrun.
REQ-012 rx_valid  output  1  rx_data holds an unread word.
REQ-013 rx_data  output  8  oldest unread word, LSB-aligned, upper bits zero.
REQ-014 rx_done  output  1  one-clk pulse per completed frame.
REQ-015 parity_err  output  1  one-clk pulse with rx_done on parity mismatch.
REQ-016 frame_err  output  1  one-clk pulse with rx_done on a low stop bit.
REQ-017 overrun  output  1  sticky: a frame was dropped because storage was full.
REQ-018 rx_busy  output  1  high in every state except IDLE.

Function
REQ-019 rx SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, and counters SHALL advance only on tick.
REQ-021 IDLE->START on synchronized rx=0; tick counter cleared.
REQ-022 START: at tick count OVERSAMPLE/2-1, if rx=0 go to DATA, else go to IDLE (false start), no flags.
REQ-023 DATA: sample at every OVERSAMPLE-th tick after the start midpoint, LSB first, for DATA_BITS bits; then go to PARITY if PARITY_MODE!=0, else STOP.
REQ-024 PARITY: sample one bit; mismatch vs XOR of data (even) or its inverse (odd) sets the frame's parity error.
REQ-025 STOP: sample STOP_BITS bits at midpoints; any 0 sets the frame's framing error.
REQ-026 At the last stop-bit midpoint, the block SHALL assert rx_done, parity_err and frame_err for one clk, push data, and enter IDLE; no wait for end of stop bit.
REQ-027 Errored frames SHALL still be pushed.
REQ-028 Push when storage is full and no same-cycle pop SHALL drop the new word and set overrun.
REQ-029 Push and pop in the same clk when full SHALL both succeed, with no overrun.
REQ-030 rd_en with rx_valid=0 SHALL be ignored.
REQ-031 Read latency: rx_data is valid combinationally while rx_valid=1, and rd_en advances it on the next clk.
REQ-032 overrun SHALL clear on clr_err; a same-cycle set wins.

Reset
REQ-033 rst SHALL force IDLE, clear counters, synchronizer flops to 1, storage empty, and all outputs 0.
REQ-034 rst mid-frame SHALL abort the frame with no rx_done.

Configuration
REQ-035 With UART_RX_FIFO_EN defined, storage SHALL be a FIFO_DEPTH-entry circular FIFO with wrap-around pointers and count.
REQ-036 Without UART_RX_FIFO_EN, storage SHALL be one holding register (full = rx_valid) and FIFO_DEPTH SHALL be ignored.

Structure
REQ-037 Shared package uart_pkg SHALL hold the PARITY_MODE encodings (PAR_NONE/PAR_EVEN/PAR_ODD) and the FSM state typedef.
REQ-038 Storage SHALL be sub-module uart_rx_fifo, instantiated only under UART_RX_FIFO_EN.

Verification
REQ-039 Defaults, tick every 4 clk, send 8N1 0xA5 -> one rx_done, rx_valid=1, rx_data=0xA5, no errors.
REQ-040 DATA_BITS=7, PARITY_MODE=1, send 0x03 with parity bit 1 -> rx_data=0x03, parity_err pulse; send again with parity bit 0 -> no error.
REQ-041 STOP_BITS=2, second stop bit driven 0 on 0x5A -> frame_err pulse, rx_data=0x5A.
REQ-042 rx low for 4 ticks then high -> FSM returns to IDLE, no rx_done, rx_valid=0.
REQ-043 FIFO enabled, depth 8, send 0x00..0x08 with no reads -> overrun=1, reads return 0x00..0x07 in order, then rx_valid=0; clr_err -> overrun=0.
REQ-044 Assert rst during bit 3 of a frame -> rx_busy=0, no rx_done; next 0x3C is received correctly.
